ct_pmp_fault_ctrl: RTL and testbench

- Sits directly downstream of the PMP lookup block.
- Consumes the per-channel permission flags (pmp_mmu_flg0..4) together with the MMU request that produced them.
- Registers a one-cycle check result per channel: access permitted or access fault.
- Captures the first faulting access into a sticky fault record that CP0 reads and clears, and counts faults lost while the record is held.

---
 rtl/ct_pmp_fault_ctrl.sv | 139 +++++++++++++
 tb/tb_ct_pmp_fault_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_pmp_fault_ctrl.sv
// PMP access-fault checker: one-cycle per-channel permit/deny responses
// plus a sticky first-fault record with a saturating lost-fault counter.
module ct_pmp_fault_ctrl #(
    parameter int NUM_CH = 5,
    parameter int PA_W   = 28,
    parameter int OVF_W  = 8
) (
    input  logic                   cpuclk,
    input  logic                   cpurst,
    input  logic [NUM_CH-1:0]      chk_req_vld,
    input  logic [2*NUM_CH-1:0]    chk_req_type,
    input  logic [PA_W*NUM_CH-1:0] chk_req_pa,
    input  logic [4*NUM_CH-1:0]    pmp_flg,
    input  logic                   chk_flush,
    input  logic                   fault_clr,
    output logic [NUM_CH-1:0]      chk_rsp_vld,
    output logic [NUM_CH-1:0]      chk_rsp_fault,
    output logic                   fault_vld,
    output logic [2:0]             fault_ch,
    output logic [1:0]             fault_type,
    output logic [PA_W-1:0]        fault_pa,
    output logic [OVF_W-1:0]       fault_ovf_cnt
);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] allow;
    logic [NUM_CH-1:0] req_live;
    logic [NUM_CH-1:0] flt;
    logic              any_flt;
    logic              multi_flt;
    logic              capture;
    logic              lost;
    logic [2:0]        cap_ch;
    logic [1:0]        cap_type;
    logic [PA_W-1:0]   cap_pa;
    logic [OVF_W-1:0]  ovf_base;
    logic [OVF_W-1:0]  ovf_nxt;
    logic              unused_flg;

    always_comb begin
        allow      = '0;
        unused_flg = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case (chk_req_type[2*i +: 2])
                2'b00:   allow[i] = pmp_flg[4*i];
                2'b01:   allow[i] = pmp_flg[4*i+1];
                2'b10:   allow[i] = pmp_flg[4*i+2];
                default: allow[i] = 1'b0;
            endcase
            unused_flg = unused_flg ^ pmp_flg[4*i+3];
        end
    end

    assign req_live  = chk_req_vld & ~{NUM_CH{chk_flush}};
    assign flt       = req_live & ~allow;
    assign any_flt   = |flt;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_flt = |(flt & (flt - NUM_CH'(1)));

    // Scan high to low so the lowest faulting channel wins.
    always_comb begin
        cap_ch   = '0;
        cap_type = chk_req_type[1:0];
        cap_pa   = chk_req_pa[PA_W-1:0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (flt[i]) begin
                cap_ch   = 3'(i);
                cap_type = chk_req_type[2*i +: 2];
                cap_pa   = chk_req_pa[PA_W*i +: PA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        lost      = 1'b0;
        ovf_base  = fault_ovf_cnt;
        unique case (state)
            IDLE: begin
                ovf_base = '0;
                if (any_flt) begin
                    state_nxt = HELD;
                    capture   = 1'b1;
                    lost      = multi_flt;
                end
            end
            HELD: begin
                if (fault_clr) begin
                    ovf_base = '0;
                    if (any_flt) begin
                        capture = 1'b1;
                        lost    = multi_flt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    lost = any_flt;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ovf_nxt = ovf_base;
        if (lost && (ovf_base != '1)) begin
            ovf_nxt = ovf_base + OVF_W'(1);
        end
    end

    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state         <= IDLE;
            chk_rsp_vld   <= '0;
            chk_rsp_fault <= '0;
            fault_ch      <= '0;
            fault_type    <= '0;
            fault_pa      <= '0;
            fault_ovf_cnt <= '0;
        end else begin
            state         <= state_nxt;
            chk_rsp_vld   <= req_live;
            chk_rsp_fault <= flt;
            fault_ovf_cnt <= ovf_nxt;
            if (capture) begin
                fault_ch   <= cap_ch;
                fault_type <= cap_type;
                fault_pa   <= cap_pa;
            end
        end
    end

    assign fault_vld = (state == HELD);

endmodule

// File: tb/tb_ct_pmp_fault_ctrl.sv
// Bench for ct_pmp_fault_ctrl: directed plan scenarios followed by
// random traffic, all checked against a fault-record reference model.
module tb_ct_pmp_fault_ctrl;

    localparam int NUM_CH = 5;
    localparam int PA_W   = 28;
    localparam int OVF_W  = 8;

    logic                   cpuclk;
    logic                   cpurst;
    logic [NUM_CH-1:0]      chk_req_vld;
    logic [2*NUM_CH-1:0]    chk_req_type;
    logic [PA_W*NUM_CH-1:0] chk_req_pa;
    logic [4*NUM_CH-1:0]    pmp_flg;
    logic                   chk_flush;
    logic                   fault_clr;
    logic [NUM_CH-1:0]      chk_rsp_vld;
    logic [NUM_CH-1:0]      chk_rsp_fault;
    logic                   fault_vld;
    logic [2:0]             fault_ch;
    logic [1:0]             fault_type;
    logic [PA_W-1:0]        fault_pa;
    logic [OVF_W-1:0]       fault_ovf_cnt;

    ct_pmp_fault_ctrl #(
        .NUM_CH(NUM_CH),
        .PA_W  (PA_W),
        .OVF_W (OVF_W)
    ) dut (
        .cpuclk       (cpuclk),
        .cpurst       (cpurst),
        .chk_req_vld  (chk_req_vld),
        .chk_req_type (chk_req_type),
        .chk_req_pa   (chk_req_pa),
        .pmp_flg      (pmp_flg),
        .chk_flush    (chk_flush),
        .fault_clr    (fault_clr),
        .chk_rsp_vld  (chk_rsp_vld),
        .chk_rsp_fault(chk_rsp_fault),
        .fault_vld    (fault_vld),
        .fault_ch     (fault_ch),
        .fault_type   (fault_type),
        .fault_pa     (fault_pa),
        .fault_ovf_cnt(fault_ovf_cnt)
    );

    initial begin
        cpuclk = 1'b0;
        forever #5 cpuclk = ~cpuclk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // stimulus for the next cycle
    logic [NUM_CH-1:0] s_vld;
    logic [1:0]        s_typ [NUM_CH];
    logic [PA_W-1:0]   s_pa  [NUM_CH];
    logic [3:0]        s_flg [NUM_CH];
    logic              s_flush;
    logic              s_clr;

    // reference model of the fault record
    bit              m_held;
    int              m_ch;
    int              m_type;
    logic [PA_W-1:0] m_pa;
    int              m_ovf;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_stim();
        s_vld   = '0;
        s_flush = 1'b0;
        s_clr   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_typ[i] = '0;
            s_pa[i]  = '0;
            s_flg[i] = '0;
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_ch   = 0;
        m_type = 0;
        m_pa   = '0;
        m_ovf  = 0;
    endtask

    task automatic check_outputs(logic [NUM_CH-1:0] ev, logic [NUM_CH-1:0] ef);
        check("rsp_vld", 64'(chk_rsp_vld), 64'(ev));
        check("rsp_fault", 64'(chk_rsp_fault), 64'(ef));
        check("fault_vld", 64'(fault_vld), 64'(m_held));
        check("fault_ch", 64'(fault_ch), 64'(m_ch));
        check("fault_type", 64'(fault_type), 64'(m_type));
        check("fault_pa", 64'(fault_pa), 64'(m_pa));
        check("ovf_cnt", 64'(fault_ovf_cnt), 64'(m_ovf));
    endtask

    task automatic step();
        logic [NUM_CH-1:0] ev;
        logic [NUM_CH-1:0] ef;
        int   nflt;
        int   first;
        bit   ok;
        chk_req_vld = s_vld;
        chk_flush   = s_flush;
        fault_clr   = s_clr;
        for (int i = 0; i < NUM_CH; i++) begin
            chk_req_type[2*i +: 2]    = s_typ[i];
            chk_req_pa[PA_W*i +: PA_W] = s_pa[i];
            pmp_flg[4*i +: 4]         = s_flg[i];
        end
        ev = '0;
        ef = '0;
        nflt = 0;
        first = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            case (s_typ[i])
                2'd0:    ok = s_flg[i][0];
                2'd1:    ok = s_flg[i][1];
                2'd2:    ok = s_flg[i][2];
                default: ok = 0;
            endcase
            ev[i] = s_vld[i] & ~s_flush;
            if (ev[i] && !ok) begin
                ef[i] = 1'b1;
                nflt++;
                if (first < 0) first = i;
            end
        end
        if (!m_held || s_clr) begin
            if (nflt > 0) begin
                m_held = 1;
                m_ch   = first;
                m_type = int'(s_typ[first]);
                m_pa   = s_pa[first];
                m_ovf  = (nflt > 1) ? 1 : 0;
            end else begin
                m_held = 0;
                m_ovf  = 0;
            end
        end else if (nflt > 0 && m_ovf < 255) begin
            m_ovf++;
        end
        @(posedge cpuclk);
        #1;
        check_outputs(ev, ef);
    endtask

    task automatic fault_one(int ch, logic [1:0] t, logic [PA_W-1:0] pa);
        clear_stim();
        s_vld[ch] = 1'b1;
        s_typ[ch] = t;
        s_pa[ch]  = pa;
        s_flg[ch] = 4'b0000;
    endtask

    initial begin
        cpurst       = 1'b1;
        chk_req_vld  = '0;
        chk_req_type = '0;
        chk_req_pa   = '0;
        pmp_flg      = '0;
        chk_flush    = 1'b0;
        fault_clr    = 1'b0;
        clear_stim();
        model_reset();
        repeat (3) @(posedge cpuclk);
        #1;
        check_outputs('0, '0);
        cpurst = 1'b0;
        repeat (10) step();

        // load permitted by R
        clear_stim();
        s_vld[0] = 1'b1;
        s_flg[0] = 4'b0001;
        step();
        check("ch0_load_ok", 64'(chk_rsp_vld[0] & ~chk_rsp_fault[0]), 64'd1);

        // store denied when only R is allowed
        clear_stim();
        s_vld[2] = 1'b1;
        s_typ[2] = 2'b01;
        s_flg[2] = 4'b0001;
        s_pa[2]  = 28'h00ABCDE;
        step();
        check("ch2_store_pa", 64'(fault_pa), 64'h00ABCDE);
        check("ch2_store_ch", 64'(fault_ch), 64'd2);

        clear_stim();
        s_clr = 1'b1;
        step();

        // two faults at once from IDLE
        clear_stim();
        s_vld[1] = 1'b1;
        s_typ[1] = 2'b10;
        s_pa[1]  = 28'h1111111;
        s_vld[3] = 1'b1;
        s_typ[3] = 2'b00;
        s_pa[3]  = 28'h3333333;
        step();
        check("simul_ch", 64'(fault_ch), 64'd1);
        check("simul_ovf", 64'(fault_ovf_cnt), 64'd1);

        clear_stim();
        s_clr = 1'b1;
        step();
        fault_one(0, 2'b01, 28'h0000055);
        step();
        for (int k = 0; k < 3; k++) begin
            fault_one(1 + k, 2'b00, 28'h0FFFFFF);
            step();
        end
        check("held_ovf3", 64'(fault_ovf_cnt), 64'd3);
        check("held_frozen_pa", 64'(fault_pa), 64'h0000055);

        clear_stim();
        s_clr = 1'b1;
        step();
        check("clr_idle", 64'({fault_vld, fault_ovf_cnt}), 64'd0);

        fault_one(2, 2'b00, 28'h0000077);
        step();
        fault_one(4, 2'b11, 28'h0000444);
        s_flg[4] = 4'b1111;
        s_clr    = 1'b1;
        step();
        check("clr_refault", 64'({fault_vld, fault_ch, fault_type}), 64'b1_100_11);

        // flushed fault is invisible
        fault_one(0, 2'b01, 28'h0000999);
        s_flush = 1'b1;
        step();

        for (int k = 0; k < 300; k++) begin
            fault_one(k % NUM_CH, 2'b10, 28'(k));
            step();
        end
        check("ovf_sat", 64'(fault_ovf_cnt), 64'hFF);

        // reset between edges must clear outputs at once
        #2;
        cpurst = 1'b1;
        #1;
        check("async_rst", 64'({chk_rsp_vld, chk_rsp_fault, fault_vld,
              fault_ch, fault_type, fault_pa, fault_ovf_cnt}), 64'd0);
        model_reset();
        repeat (2) @(posedge cpuclk);
        #1;
        cpurst = 1'b0;
        clear_stim();
        step();

        for (int k = 0; k < 1500; k++) begin
            clear_stim();
            s_vld   = NUM_CH'($urandom());
            s_flush = ($urandom_range(0, 9) == 0);
            s_clr   = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                s_typ[i] = 2'($urandom());
                s_pa[i]  = PA_W'($urandom());
                s_flg[i] = 4'($urandom());
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
